// File: rtl/pc_fetch_predict.sv
// pc_fetch_predict: fetch PC register with next-PC selection and a
// direct-mapped BTB using 2-bit saturating counters.
//
// Ports
//   clk          in   1      clock, rising edge
//   rst          in   1      synchronous reset, active-low
//   stall_f      in   1      hold PC
//   redirect     in   1      load redirect_pc (overrides stall_f)
//   redirect_pc  in   WIDTH  corrected fetch address
//   upd_valid    in   1      train BTB this cycle
//   upd_pc       in   WIDTH  address of resolved control-flow instruction
//   upd_target   in   WIDTH  resolved target
//   upd_taken    in   1      resolved direction
//   PC           out  WIDTH  current fetch address (registered)
//   PCPlus4      out  WIDTH  PC + 4 (combinational)
//   pred_taken   out  1      BTB predicts taken for PC (combinational)
//   pred_target  out  WIDTH  predicted target, 0 when not predicted taken
module pc_fetch_predict #(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter int unsigned       BTB_ENTRIES  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_f,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic [WIDTH-1:0] upd_target,
  input  logic             upd_taken,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPlus4,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target
);

  localparam int unsigned IDX = $clog2(BTB_ENTRIES);
  localparam int unsigned TAG = WIDTH - IDX - 2;
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  logic [WIDTH-1:0] pc_q, pc_d;

  logic             valid_q  [BTB_ENTRIES];
  logic [TAG-1:0]   tag_q    [BTB_ENTRIES];
  logic [WIDTH-1:0] target_q [BTB_ENTRIES];
  logic [1:0]       ctr_q    [BTB_ENTRIES];

  // Low address bits of upd_pc carry no information for word-aligned code.
  logic unused_upd_lsb_c;
  assign unused_upd_lsb_c = ^upd_pc[1:0];

  // Lookup from the current PC; sees pre-update contents.
  logic [IDX-1:0] lk_idx_c;
  logic [TAG-1:0] lk_tag_c;
  logic           lk_hit_c;

  assign lk_idx_c    = pc_q[IDX+1:2];
  assign lk_tag_c    = pc_q[WIDTH-1:IDX+2];
  assign lk_hit_c    = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == lk_tag_c);
  assign PC          = pc_q;
  assign PCPlus4     = pc_q + WIDTH'(4);
  assign pred_taken  = lk_hit_c && ctr_q[lk_idx_c][1];
  assign pred_target = pred_taken ? target_q[lk_idx_c] : '0;

  // Next-PC select: redirect > stall > prediction > sequential.
  always_comb begin
    pc_d = PCPlus4;
    if (redirect) begin
      pc_d = redirect_pc & ALIGN_MASK;
    end else if (stall_f) begin
      pc_d = pc_q;
    end else if (pred_taken) begin
      pc_d = pred_target;
    end
  end

  // Training: compute the new contents of the single indexed entry.
  logic [IDX-1:0]   upd_idx_c;
  logic [TAG-1:0]   upd_tag_c;
  logic             upd_hit_c;
  logic             upd_we_c;
  logic [TAG-1:0]   upd_tag_d;
  logic [WIDTH-1:0] upd_target_d;
  logic [1:0]       upd_ctr_d;

  assign upd_idx_c = upd_pc[IDX+1:2];
  assign upd_tag_c = upd_pc[WIDTH-1:IDX+2];
  assign upd_hit_c = valid_q[upd_idx_c] && (tag_q[upd_idx_c] == upd_tag_c);

  always_comb begin
    upd_we_c     = 1'b0;
    upd_tag_d    = tag_q[upd_idx_c];
    upd_target_d = target_q[upd_idx_c];
    upd_ctr_d    = ctr_q[upd_idx_c];
    if (upd_valid) begin
      if (upd_hit_c) begin
        upd_we_c = 1'b1;
        if (upd_taken) begin
          upd_target_d = upd_target & ALIGN_MASK;
          if (ctr_q[upd_idx_c] != 2'b11) upd_ctr_d = ctr_q[upd_idx_c] + 2'd1;
        end else begin
          if (ctr_q[upd_idx_c] != 2'b00) upd_ctr_d = ctr_q[upd_idx_c] - 2'd1;
        end
      end else if (upd_taken) begin
        // Allocate or replace the aliasing entry, starting at weak-taken.
        upd_we_c     = 1'b1;
        upd_tag_d    = upd_tag_c;
        upd_target_d = upd_target & ALIGN_MASK;
        upd_ctr_d    = 2'b10;
      end
    end
  end

  // PC and BTB state; reset drops any concurrent update.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_VECTOR & ALIGN_MASK;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
    end else begin
      pc_q <= pc_d;
      if (upd_we_c) begin
        valid_q[upd_idx_c]  <= 1'b1;
        tag_q[upd_idx_c]    <= upd_tag_d;
        target_q[upd_idx_c] <= upd_target_d;
        ctr_q[upd_idx_c]    <= upd_ctr_d;
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_predict.sv
// Directed bench for pc_fetch_predict (WIDTH=32, BTB_ENTRIES=16, reset vector 0).
module tb_pc_fetch_predict;

  logic        clk;
  logic        rst;
  logic        stall_f;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        pred_taken;
  logic [31:0] pred_target;

  int n_cmp;
  int n_err;

  pc_fetch_predict #(
    .WIDTH(32),
    .RESET_VECTOR(32'h0000_0000),
    .BTB_ENTRIES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .stall_f(stall_f),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .upd_valid(upd_valid),
    .upd_pc(upd_pc),
    .upd_target(upd_target),
    .upd_taken(upd_taken),
    .PC(PC),
    .PCPlus4(PCPlus4),
    .pred_taken(pred_taken),
    .pred_target(pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one edge, then let outputs settle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic upd(input logic v, input logic [31:0] p, input logic [31:0] t, input logic tk);
    upd_valid  = v;
    upd_pc     = p;
    upd_target = t;
    upd_taken  = tk;
  endtask

  task automatic redir(input logic r, input logic [31:0] p);
    redirect    = r;
    redirect_pc = p;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0; stall_f = 1'b0;
    redir(1'b0, 32'h0);
    upd(1'b0, 32'h0, 32'h0, 1'b0);

    // Reset for two cycles, then sequential fetch.
    tick(); tick();
    check_eq("reset_pc", PC, 32'h0);
    check_eq("reset_pred", 32'(pred_taken), 32'h0);
    rst = 1'b1;
    tick(); check_eq("seq_pc4", PC, 32'h4);
    check_eq("seq_pred4", 32'(pred_taken), 32'h0);
    tick(); check_eq("seq_pc8", PC, 32'h8);
    tick(); check_eq("seq_pcC", PC, 32'hC);
    check_eq("seq_predC", 32'(pred_taken), 32'h0);
    tick(); check_eq("seq_pc10", PC, 32'h10);

    // Stall holds; redirect beats stall and is aligned.
    stall_f = 1'b1;
    tick(); check_eq("stall_hold", PC, 32'h10);
    redir(1'b1, 32'h203);
    tick(); check_eq("redirect_align", PC, 32'h200);
    check_eq("pcplus4", PCPlus4, 32'h204);
    stall_f = 1'b0; redir(1'b0, 32'h0);

    // Train 0x20 taken -> 0x80, then fetch it.
    upd(1'b1, 32'h20, 32'h80, 1'b1);
    tick(); check_eq("train_pc", PC, 32'h204);
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    redir(1'b1, 32'h20);
    tick(); redir(1'b0, 32'h0); #1;
    check_eq("pred_hit", 32'(pred_taken), 32'h1);
    check_eq("pred_tgt", pred_target, 32'h80);
    tick(); check_eq("pred_follow", PC, 32'h80);

    // Hysteresis with PC parked at 0x20 (ctr 10).
    redir(1'b1, 32'h20); stall_f = 1'b1;
    tick(); redir(1'b0, 32'h0);
    upd(1'b1, 32'h20, 32'h84, 1'b1); #1;
    check_eq("same_idx_old_tgt", pred_target, 32'h80);
    tick();
    check_eq("upd_new_tgt", pred_target, 32'h84);
    upd(1'b1, 32'h20, 32'h999, 1'b0);
    tick();
    check_eq("hyst_nt1_taken", 32'(pred_taken), 32'h1);
    check_eq("hyst_nt1_tgt", pred_target, 32'h84);
    #1;
    check_eq("same_idx_old_pred", 32'(pred_taken), 32'h1);
    tick();
    check_eq("hyst_nt2_pred", 32'(pred_taken), 32'h0);
    check_eq("hyst_nt2_tgt", pred_target, 32'h0);
    check_eq("stalled_pc", PC, 32'h20);

    // Aliasing: 0x60 shares index with 0x20 and evicts it.
    upd(1'b1, 32'h20, 32'h80, 1'b1);
    tick();
    check_eq("retrain_pred", 32'(pred_taken), 32'h1);
    check_eq("retrain_tgt", pred_target, 32'h80);
    upd(1'b1, 32'h60, 32'h100, 1'b1);
    tick();
    check_eq("alias_miss", 32'(pred_taken), 32'h0);
    upd(1'b0, 32'h0, 32'h0, 1'b0); stall_f = 1'b0;
    tick(); check_eq("alias_seq", PC, 32'h24);

    // Miss with not-taken must not allocate.
    upd(1'b1, 32'h30, 32'h500, 1'b0);
    tick(); upd(1'b0, 32'h0, 32'h0, 1'b0);
    redir(1'b1, 32'h30);
    tick(); redir(1'b0, 32'h0); #1;
    check_eq("miss_nt_noalloc", 32'(pred_taken), 32'h0);

    // Address wrap.
    redir(1'b1, 32'hFFFF_FFFC);
    tick(); redir(1'b0, 32'h0); #1;
    check_eq("wrap_pc", PC, 32'hFFFF_FFFC);
    check_eq("wrap_plus4", PCPlus4, 32'h0);
    check_eq("wrap_pred", 32'(pred_taken), 32'h0);
    tick(); check_eq("wrap_next", PC, 32'h0);

    // Reset drops a concurrent update and clears the BTB.
    redir(1'b1, 32'h60);
    tick(); redir(1'b0, 32'h0); #1;
    check_eq("pre_rst_pred", 32'(pred_taken), 32'h1);
    check_eq("pre_rst_tgt", pred_target, 32'h100);
    rst = 1'b0;
    upd(1'b1, 32'h60, 32'h100, 1'b1);
    redir(1'b1, 32'h60);
    tick(); check_eq("rst_pc", PC, 32'h0);
    rst = 1'b1;
    upd(1'b0, 32'h0, 32'h0, 1'b0);
    tick(); redir(1'b0, 32'h0); #1;
    check_eq("post_rst_pc", PC, 32'h60);
    check_eq("post_rst_empty", 32'(pred_taken), 32'h0);
    tick(); check_eq("post_rst_seq", PC, 32'h64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
